// File: rtl/fxf_pkg.sv
// Shared constants, binary32 layout and width helper for the fixed-to-float pipeline.
package fxf_pkg;

    localparam int FP32_BIAS   = 127;
    localparam int FP32_MANT_W = 23;
    localparam int FP32_EXP_W  = 8;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_MANT_W-1:0] mant;
    } fp32_t;

    // Bits needed to encode values 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fxf_lzc.sv
// Combinational leading-one detector: position of the highest set bit plus an all-zero flag.
module fxf_lzc
    import fxf_pkg::*;
#(
    parameter int WIDTH = 22,
    localparam int PW   = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [PW-1:0]    pos_o,
    output logic             zero_o
);

    always_comb begin
        pos_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) pos_o = PW'(i);
        end
    end

    assign zero_o = ~|vec_i;

endmodule

// File: rtl/fixed_to_float_pipe.sv
// Three-stage fixed-point to IEEE-754 binary32 converter with valid/ready streaming.
// Define FXF_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates toward zero.
module fixed_to_float_pipe
    import fxf_pkg::*;
#(
    parameter int DATA_W    = 22,
    parameter int FRAC_W    = 20,
    parameter int SIGN_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_inexact
);

    localparam int PW = clog2(DATA_W);
    localparam int EW = DATA_W + FP32_MANT_W + 2;

    logic advance;

    logic              s1_valid_q;
    logic              s1_sign_q;
    logic [DATA_W-1:0] s1_mag_q;
    logic              s1_sign_d;
    logic [DATA_W-1:0] s1_mag_d;

    logic                   s2_valid_q;
    logic                   s2_sign_q;
    logic                   s2_zero_q;
    logic [FP32_EXP_W-1:0]  s2_exp_q;
    logic [FP32_MANT_W-1:0] s2_frac_q;
    logic                   s2_guard_q;
    logic                   s2_sticky_q;
    logic                   s2_zero_d;
    logic [FP32_EXP_W-1:0]  s2_exp_d;
    logic [FP32_MANT_W-1:0] s2_frac_d;
    logic                   s2_guard_d;
    logic                   s2_sticky_d;

    logic          out_valid_q;
    fp32_t         out_data_q;
    logic          out_inexact_q;
    fp32_t         out_data_d;
    logic          out_inexact_d;

    logic [PW-1:0]        lzc_pos;
    logic                 lzc_zero;
    logic [PW-1:0]        shamt;
    logic [EW-1:0]        norm_ext;
    logic                 round_up;
    logic [FP32_MANT_W:0] frac_sum;

    // Every stage moves in lockstep; bubbles travel like data.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_inexact = out_inexact_q;

    generate
        if (SIGN_MODE == 1) begin : g_twos
            assign s1_sign_d = in_data[DATA_W-1];
            assign s1_mag_d  = s1_sign_d ? (~in_data + DATA_W'(1)) : in_data;
        end else begin : g_signmag
            assign s1_sign_d = in_data[DATA_W-1];
            assign s1_mag_d  = {1'b0, in_data[DATA_W-2:0]};
        end
    endgenerate

    fxf_lzc #(
        .WIDTH (DATA_W)
    ) u_lzc (
        .vec_i  (s1_mag_q),
        .pos_o  (lzc_pos),
        .zero_o (lzc_zero)
    );

    // Leading one lands on norm_ext[EW-1]; 25 zero bits below keep small widths aligned.
    assign shamt       = PW'(DATA_W - 1) - lzc_pos;
    assign norm_ext    = {s1_mag_q, {(FP32_MANT_W + 2){1'b0}}} << shamt;
    assign s2_frac_d   = norm_ext[EW-2 -: FP32_MANT_W];
    assign s2_guard_d  = norm_ext[DATA_W];
    assign s2_sticky_d = |norm_ext[DATA_W-1:0];
    assign s2_zero_d   = lzc_zero || !norm_ext[EW-1];
    assign s2_exp_d    = FP32_EXP_W'(10'(FP32_BIAS - FRAC_W) + 10'(lzc_pos));

`ifdef FXF_ROUND_NEAREST_EN
    assign round_up = s2_guard_q & (s2_sticky_q | s2_frac_q[0]);
`else
    assign round_up = 1'b0;
`endif

    assign frac_sum = {1'b0, s2_frac_q} + {{FP32_MANT_W{1'b0}}, round_up};

    always_comb begin
        out_data_d    = '0;
        out_inexact_d = 1'b0;
        if (!s2_zero_q) begin
            out_data_d.sign = s2_sign_q;
            out_data_d.exp  = s2_exp_q + FP32_EXP_W'(frac_sum[FP32_MANT_W]);
            out_data_d.mant = frac_sum[FP32_MANT_W-1:0];
            out_inexact_d   = s2_guard_q | s2_sticky_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_mag_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_zero_q     <= 1'b1;
            s2_exp_q      <= '0;
            s2_frac_q     <= '0;
            s2_guard_q    <= 1'b0;
            s2_sticky_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q    <= in_valid;
            s1_sign_q     <= s1_sign_d;
            s1_mag_q      <= s1_mag_d;
            s2_valid_q    <= s1_valid_q;
            s2_sign_q     <= s1_sign_q & ~s2_zero_d;
            s2_zero_q     <= s2_zero_d;
            s2_exp_q      <= s2_exp_d;
            s2_frac_q     <= s2_frac_d;
            s2_guard_q    <= s2_guard_d;
            s2_sticky_q   <= s2_sticky_d;
            out_valid_q   <= s2_valid_q;
            out_data_q    <= out_data_d;
            out_inexact_q <= out_inexact_d;
        end
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Directed bench: default 22/20 sign-magnitude instance plus a 32/0 two's-complement instance.
module tb_fixed_to_float_pipe;

    logic clk = 1'b0;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_inexact;
    logic [21:0] a_in_data;
    logic [31:0] a_out_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_inexact;
    logic [31:0] b_in_data;
    logic [31:0] b_out_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fixed_to_float_pipe u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_data     (a_in_data),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_data    (a_out_data),
        .out_inexact (a_out_inexact)
    );

    fixed_to_float_pipe #(
        .DATA_W    (32),
        .FRAC_W    (0),
        .SIGN_MODE (1)
    ) u_dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_data     (b_in_data),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_data    (b_out_data),
        .out_inexact (b_out_inexact)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic run22(input string tag, input logic [21:0] d, input logic [31:0] want, input logic want_inx);
        int n;
        @(negedge clk);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = d;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n = 1;
        while (!a_out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd3);
        check({tag, "_data"}, 64'(a_out_data), 64'(want));
        check({tag, "_inx"}, 64'(a_out_inexact), 64'(want_inx));
    endtask

    task automatic run32(input string tag, input logic [31:0] d, input logic [31:0] want, input logic want_inx);
        int n;
        @(negedge clk);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = d;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd3);
        check({tag, "_data"}, 64'(b_out_data), 64'(want));
        check({tag, "_inx"}, 64'(b_out_inexact), 64'(want_inx));
    endtask

    logic [21:0] bp_in  [8];
    logic [31:0] bp_exp [8];

    initial begin
        int iidx, oidx, extra;
        logic rdy, stall;
        logic [31:0] held;

        bp_in  = '{22'h100000, 22'h080000, 22'h040000, 22'h300000,
                   22'h000001, 22'h1FFFFF, 22'h200000, 22'h0C0000};
        bp_exp = '{32'h3F80_0000, 32'h3F00_0000, 32'h3E80_0000, 32'hBF80_0000,
                   32'h3580_0000, 32'h3FFF_FFF8, 32'h0000_0000, 32'h3F40_0000};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_inexact", 64'(a_out_inexact), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        rst_n = 1'b1;

        // Default instance: Q1.20 sign-magnitude
        run22("one",      22'h100000, 32'h3F80_0000, 1'b0);
        run22("neg_one",  22'h300000, 32'hBF80_0000, 1'b0);
        run22("lsb",      22'h000001, 32'h3580_0000, 1'b0);
        run22("max",      22'h1FFFFF, 32'h3FFF_FFF8, 1'b0);
        run22("neg_zero", 22'h200000, 32'h0000_0000, 1'b0);
        run22("neg_3q",   22'h2C0000, 32'hBF40_0000, 1'b0);

        // 32-bit integer, two's complement
        run32("most_neg", 32'h8000_0000, 32'hCF00_0000, 1'b0);
        run32("minus1",   32'hFFFF_FFFF, 32'hBF80_0000, 1'b0);
        run32("zero32",   32'h0000_0000, 32'h0000_0000, 1'b0);
`ifdef FXF_ROUND_NEAREST_EN
        run32("most_pos", 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1);
        run32("tie_even", 32'h0100_0001, 32'h4B80_0000, 1'b1);
        run32("tie_odd",  32'h0100_0003, 32'h4B80_0002, 1'b1);
`else
        run32("most_pos", 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1);
        run32("tie_even", 32'h0100_0001, 32'h4B80_0000, 1'b1);
        run32("tie_odd",  32'h0100_0003, 32'h4B80_0001, 1'b1);
`endif

        // Backpressure: 8 words back-to-back, out_ready toggling every cycle
        iidx = 0; oidx = 0; rdy = 1'b1; stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && oidx < 8; cyc++) begin
            @(negedge clk);
            a_in_valid  = (iidx < 8);
            a_in_data   = bp_in[iidx % 8];
            a_out_ready = rdy;
            rdy = !rdy;
            #1;
            if (stall) check("bp_hold", 64'(a_out_data), 64'(held));
            check("bp_in_ready", 64'(a_in_ready), 64'(!(a_out_valid && !a_out_ready)));
            stall = a_out_valid && !a_out_ready;
            held  = a_out_data;
            if (a_out_valid && a_out_ready) begin
                check("bp_order", 64'(a_out_data), 64'(bp_exp[oidx]));
                oidx++;
            end
            if (a_in_valid && a_in_ready) iidx++;
        end
        check("bp_count", 64'(oidx), 64'd8);
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_out_valid) extra++;
        end
        check("bp_no_dup", 64'(extra), 64'd0);

        // Asynchronous reset with three words in flight
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_data  = bp_in[i];
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        check("fl_valid_before", 64'(a_out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("fl_valid_async", 64'(a_out_valid), 64'd0);
        check("fl_data_async", 64'(a_out_data), 64'd0);
        check("fl_ready_in_rst", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_out_valid) extra++;
        end
        check("fl_no_stale", 64'(extra), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
